// File: rtl/sort_scheduler.sv
// sort_scheduler
//
// This block lets two requesters share one 30-entry, 7-bit sorting engine.
// A requester raises Req with its array and width. The scheduler arbitrates
// between the two and captures the winning job. It then drives the engine's
// Start/Done/Ack handshake and returns the sorted array to the winner under
// a Rdy/Rack handshake. A job whose width exceeds N is rejected without using
// the engine. In that case it is returned unchanged with Err set.
//
// Optional feature: define SORT_SCHED_RR_EN for round-robin arbitration.
// Without it, arbitration is fixed priority and requester 0 always wins ties.
//
// Ports
//   Clk, Reset          rising-edge clock; synchronous active-high reset
//   Req0/Req1           level job requests
//   Width0/Width1       number of valid entries (0..31)
//   Ain0/Ain1           input arrays, entry i in bits [i*W +: W]
//   Rack0/Rack1         requester accepts its result
//   Grant0/Grant1       one-cycle pulse when a job is captured
//   Rdy0/Rdy1           result valid for that requester
//   Aout, Err           shared result array and reject flag, valid with Rdy
//   Busy                high whenever the scheduler is not idle
//   S_Start, S_Ack      engine handshake outputs
//   S_Width, S_Ain      captured job presented to the engine
//   S_Aout, S_Done      engine result and completion flag
module sort_scheduler #(
    parameter int N = 30,
    parameter int W = 7
) (
    input  logic           Clk,
    input  logic           Reset,
    input  logic           Req0,
    input  logic           Req1,
    input  logic [4:0]     Width0,
    input  logic [4:0]     Width1,
    input  logic [N*W-1:0] Ain0,
    input  logic [N*W-1:0] Ain1,
    input  logic           Rack0,
    input  logic           Rack1,
    output logic           Grant0,
    output logic           Grant1,
    output logic           Rdy0,
    output logic           Rdy1,
    output logic [N*W-1:0] Aout,
    output logic           Err,
    output logic           Busy,
    output logic           S_Start,
    output logic           S_Ack,
    output logic [4:0]     S_Width,
    output logic [N*W-1:0] S_Ain,
    input  logic [N*W-1:0] S_Aout,
    input  logic           S_Done
);

    localparam logic [4:0] MAX_WIDTH = 5'(N);

    // One-hot state encoding. Any other code falls back to IDLE.
    typedef enum logic [4:0] {
        IDLE    = 5'b00001,
        START   = 5'b00010,
        WAIT    = 5'b00100,
        DELIVER = 5'b01000,
        RELEASE = 5'b10000
    } state_e;

    state_e         state_q, state_d;
    logic           owner_q, owner_d;
    logic           err_q, err_d;
    logic [1:0]     grant_q, grant_d;
    logic [4:0]     job_width_q, job_width_d;
    logic [N*W-1:0] job_ain_q, job_ain_d;
    logic [N*W-1:0] result_q, result_d;

    logic           winner;
    logic [4:0]     sel_width;
    logic [N*W-1:0] sel_ain;
    logic           owner_rack;

`ifdef SORT_SCHED_RR_EN
    logic           last_owner_q, last_owner_d;

    // On a tie, the requester not served last wins. After reset,
    // last_owner_q is 1, so requester 0 wins the first tie.
    assign winner = (Req0 && Req1) ? ~last_owner_q : ~Req0;
`else
    assign winner = ~Req0;
`endif

    assign sel_width  = winner ? Width1 : Width0;
    assign sel_ain    = winner ? Ain1   : Ain0;
    // Only the owner's Rack counts. The other requester's Rack is ignored.
    assign owner_rack = owner_q ? Rack1 : Rack0;

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path leaves one unassigned and no latch is inferred.
        state_d     = state_q;
        owner_d     = owner_q;
        err_d       = err_q;
        grant_d     = 2'b00;
        job_width_d = job_width_q;
        job_ain_d   = job_ain_q;
        result_d    = result_q;
`ifdef SORT_SCHED_RR_EN
        last_owner_d = last_owner_q;
`endif

        case (state_q)
            IDLE: begin
                if (Req0 || Req1) begin
                    owner_d          = winner;
                    grant_d[winner]  = 1'b1;
                    job_width_d      = sel_width;
                    job_ain_d        = sel_ain;
`ifdef SORT_SCHED_RR_EN
                    last_owner_d     = winner;
`endif
                    if (sel_width > MAX_WIDTH) begin
                        // Rejected: return the array untouched, skip the engine.
                        err_d    = 1'b1;
                        result_d = sel_ain;
                        state_d  = DELIVER;
                    end else begin
                        err_d    = 1'b0;
                        state_d  = START;
                    end
                end
            end
            START: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (S_Done) begin
                    result_d = S_Aout;
                    err_d    = 1'b0;
                    state_d  = DELIVER;
                end
            end
            DELIVER: begin
                if (owner_rack) begin
                    // A rejected job never used the engine, so there is nothing to ack.
                    state_d = err_q ? IDLE : RELEASE;
                end
            end
            RELEASE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            // NOTE: the wide job/result registers are cleared too, because S_Ain and Aout must read zero after reset.
            state_q     <= IDLE;
            owner_q     <= 1'b0;
            err_q       <= 1'b0;
            grant_q     <= 2'b00;
            job_width_q <= '0;
            job_ain_q   <= '0;
            result_q    <= '0;
`ifdef SORT_SCHED_RR_EN
            last_owner_q <= 1'b1;
`endif
        end else begin
            // NOTE: non-blocking assignments make every flop sample pre-edge values.
            state_q     <= state_d;
            owner_q     <= owner_d;
            err_q       <= err_d;
            grant_q     <= grant_d;
            job_width_q <= job_width_d;
            job_ain_q   <= job_ain_d;
            result_q    <= result_d;
`ifdef SORT_SCHED_RR_EN
            last_owner_q <= last_owner_d;
`endif
        end
    end

    // Every control output is decoded from registered state only.
    assign Grant0  = grant_q[0];
    assign Grant1  = grant_q[1];
    assign Rdy0    = (state_q == DELIVER) && !owner_q;
    assign Rdy1    = (state_q == DELIVER) &&  owner_q;
    assign Err     = (state_q == DELIVER) &&  err_q;
    assign Busy    = (state_q != IDLE);
    assign S_Start = (state_q == START);
    assign S_Ack   = (state_q == RELEASE);
    assign Aout    = result_q;
    assign S_Width = job_width_q;
    assign S_Ain   = job_ain_q;

endmodule

// File: tb/tb_sort_scheduler.sv
// Testbench for sort_scheduler. It contains a behavioural model of the
// scheduler, a sorting-engine model that answers the Start/Done/Ack
// handshake, and directed scenarios with hand-computed expectations.
module tb_sort_scheduler;

    localparam int N  = 30;
    localparam int W  = 7;
    localparam int AW = N * W;

    logic          Clk = 1'b0;
    logic          Reset = 1'b1;
    logic          Req0 = 1'b0, Req1 = 1'b0;
    logic [4:0]    Width0 = '0, Width1 = '0;
    logic [AW-1:0] Ain0 = '0, Ain1 = '0;
    logic          Rack0 = 1'b0, Rack1 = 1'b0;
    logic          Grant0, Grant1, Rdy0, Rdy1, Err, Busy, S_Start, S_Ack;
    logic [AW-1:0] Aout, S_Ain;
    logic [4:0]    S_Width;
    logic [AW-1:0] S_Aout = '0;
    logic          S_Done = 1'b0;

    int checks = 0;
    int errors = 0;

    sort_scheduler dut (
        .Clk(Clk), .Reset(Reset),
        .Req0(Req0), .Req1(Req1),
        .Width0(Width0), .Width1(Width1),
        .Ain0(Ain0), .Ain1(Ain1),
        .Rack0(Rack0), .Rack1(Rack1),
        .Grant0(Grant0), .Grant1(Grant1),
        .Rdy0(Rdy0), .Rdy1(Rdy1),
        .Aout(Aout), .Err(Err), .Busy(Busy),
        .S_Start(S_Start), .S_Ack(S_Ack),
        .S_Width(S_Width), .S_Ain(S_Ain),
        .S_Aout(S_Aout), .S_Done(S_Done)
    );

    always #5 Clk = ~Clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    // ------------------------------------------------------------------ helpers
    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b, required %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkv(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [AW-1:0] mk5(input int v0, input int v1, input int v2,
                                          input int v3, input int v4);
        logic [AW-1:0] r;
        r = '0;
        r[0*W +: W] = W'(v0);
        r[1*W +: W] = W'(v1);
        r[2*W +: W] = W'(v2);
        r[3*W +: W] = W'(v3);
        r[4*W +: W] = W'(v4);
        return r;
    endfunction

    // Ascending sort of the first w entries. Entries beyond w are left as they are.
    function automatic logic [AW-1:0] sort_ref(input logic [AW-1:0] a, input logic [4:0] w);
        logic [W-1:0]  e [N];
        logic [W-1:0]  t;
        logic [AW-1:0] r;
        int            n;
        n = (int'(w) > N) ? N : int'(w);
        for (int i = 0; i < N; i++) e[i] = a[i*W +: W];
        for (int i = 0; i < n; i++)
            for (int j = 0; j + 1 < n - i; j++)
                if (e[j] > e[j+1]) begin
                    t = e[j]; e[j] = e[j+1]; e[j+1] = t;
                end
        r = '0;
        for (int i = 0; i < N; i++) r[i*W +: W] = e[i];
        return r;
    endfunction

    // ------------------------------------------------------------ engine model
    // Start clears Done and launches a sort that finishes after eng_lat cycles.
    // Done then stays high until Ack.
    int   eng_lat = 3;
    int   eng_cnt = 0;
    logic eng_run = 1'b0;

    always @(posedge Clk) begin
        if (Reset) begin
            S_Done  <= 1'b0;
            S_Aout  <= '0;
            eng_run <= 1'b0;
            eng_cnt <= 0;
        end else begin
            if (S_Start) begin
                eng_run <= 1'b1;
                eng_cnt <= eng_lat;
                S_Done  <= 1'b0;
            end else if (eng_run) begin
                if (eng_cnt <= 1) begin
                    S_Done  <= 1'b1;
                    S_Aout  <= sort_ref(S_Ain, S_Width);
                    eng_run <= 1'b0;
                end else begin
                    eng_cnt <= eng_cnt - 1;
                end
            end
            if (S_Ack) S_Done <= 1'b0;
        end
    end

    // --------------------------------------------------------- scheduler model
    // The job lifecycle is: free -> engine launched -> engine running ->
    // result offered -> engine acknowledged -> free. A rejected job goes
    // straight from free to result offered and back.
    typedef enum logic [2:0] {PH_FREE, PH_LAUNCH, PH_RUN, PH_OFFER, PH_ACK} phase_e;

    phase_e        m_ph = PH_FREE;
    logic          m_owner = 1'b0;
    logic          m_err = 1'b0;
    logic [1:0]    m_grant = 2'b00;
    logic [4:0]    m_job_w = '0;
    logic [AW-1:0] m_job_ain = '0;
    logic [AW-1:0] m_result = '0;
    logic          m_pick;

`ifdef SORT_SCHED_RR_EN
    logic m_last = 1'b1;
    // On a tie, favour whoever was not served last. Otherwise the sole requester wins.
    assign m_pick = (Req0 && Req1) ? !m_last : Req1;
`else
    // Requester 0 wins whenever it asks.
    assign m_pick = Req0 ? 1'b0 : 1'b1;
`endif

    always @(posedge Clk) begin
        m_grant <= 2'b00;
        if (Reset) begin
            m_ph      <= PH_FREE;
            m_owner   <= 1'b0;
            m_err     <= 1'b0;
            m_job_w   <= '0;
            m_job_ain <= '0;
            m_result  <= '0;
`ifdef SORT_SCHED_RR_EN
            m_last    <= 1'b1;
`endif
        end else begin
            case (m_ph)
                PH_FREE: if (Req0 || Req1) begin
                    m_owner   <= m_pick;
                    m_grant   <= m_pick ? 2'b10 : 2'b01;
                    m_job_w   <= m_pick ? Width1 : Width0;
                    m_job_ain <= m_pick ? Ain1 : Ain0;
`ifdef SORT_SCHED_RR_EN
                    m_last    <= m_pick;
`endif
                    if ((m_pick ? Width1 : Width0) > 5'd30) begin
                        m_err    <= 1'b1;
                        m_result <= m_pick ? Ain1 : Ain0;
                        m_ph     <= PH_OFFER;
                    end else begin
                        m_err    <= 1'b0;
                        m_ph     <= PH_LAUNCH;
                    end
                end
                PH_LAUNCH: m_ph <= PH_RUN;
                PH_RUN: if (S_Done) begin
                    m_result <= sort_ref(m_job_ain, m_job_w);
                    m_ph     <= PH_OFFER;
                end
                PH_OFFER: if (m_owner ? Rack1 : Rack0)
                    m_ph <= m_err ? PH_FREE : PH_ACK;
                PH_ACK: m_ph <= PH_FREE;
                default: m_ph <= PH_FREE;
            endcase
        end
    end

    // -------------------------------------------------------- compare process
    logic cmp_en = 1'b0;
    int   ack_cnt = 0;
    int   start_cnt = 0;
    logic grant_log [$];

    always @(negedge Clk) begin
        if (cmp_en) begin
            check1("grant0", Grant0, m_grant[0]);
            check1("grant1", Grant1, m_grant[1]);
            check1("busy", Busy, m_ph != PH_FREE);
            check1("s_start", S_Start, m_ph == PH_LAUNCH);
            check1("s_ack", S_Ack, m_ph == PH_ACK);
            check1("rdy0", Rdy0, (m_ph == PH_OFFER) && !m_owner);
            check1("rdy1", Rdy1, (m_ph == PH_OFFER) && m_owner);
            checkv("s_width", AW'(S_Width), AW'(m_job_w));
            checkv("s_ain", S_Ain, m_job_ain);
            if (m_ph == PH_OFFER) begin
                check1("err", Err, m_err);
                checkv("aout", Aout, m_result);
            end
            if (S_Ack) ack_cnt++;
            if (S_Start) start_cnt++;
            if (Grant0 || Grant1) grant_log.push_back(Grant1);
        end
    end

    // --------------------------------------------------------------- stimulus
    localparam int SIG_G0 = 0, SIG_G1 = 1, SIG_R0 = 2, SIG_R1 = 3, SIG_IDLE = 4, SIG_GANY = 5;

    function automatic logic sig(input int k);
        case (k)
            SIG_G0:   return Grant0;
            SIG_G1:   return Grant1;
            SIG_R0:   return Rdy0;
            SIG_R1:   return Rdy1;
            SIG_IDLE: return !Busy;
            default:  return Grant0 || Grant1;
        endcase
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic wait_sig(input int k, input int budget, input string what);
        int n;
        n = 0;
        while (!sig(k) && n < budget) begin
            tick();
            n++;
        end
        check1(what, sig(k), 1'b1);
    endtask

    task automatic do_rack(input logic who);
        if (who) Rack1 = 1'b1; else Rack0 = 1'b1;
        tick();
        Rack0 = 1'b0;
        Rack1 = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check1({tag, " grant0"}, Grant0, 1'b0);
        check1({tag, " grant1"}, Grant1, 1'b0);
        check1({tag, " rdy0"}, Rdy0, 1'b0);
        check1({tag, " rdy1"}, Rdy1, 1'b0);
        check1({tag, " err"}, Err, 1'b0);
        check1({tag, " busy"}, Busy, 1'b0);
        check1({tag, " s_start"}, S_Start, 1'b0);
        check1({tag, " s_ack"}, S_Ack, 1'b0);
        checkv({tag, " s_width"}, AW'(S_Width), '0);
        checkv({tag, " s_ain"}, S_Ain, '0);
        checkv({tag, " aout"}, Aout, '0);
    endtask

    initial begin
        int            base;
        int            ack_base;
        int            start_base;
        logic          own;
        logic [2:0]    exp_order;
        logic [AW-1:0] held;
`ifdef SORT_SCHED_RR_EN
        exp_order = 3'b010;   // rounds 0,1,2 won by requesters 0,1,0
`else
        exp_order = 3'b000;   // requester 0 wins every round
`endif

        // Reset state
        tick();
        cmp_en = 1'b1;
        tick();
        check_all_zero("reset");
        Reset = 1'b0;
        tick();

        // Basic sort of 5 entries
        ack_base = ack_cnt;
        Ain0 = mk5(9, 3, 7, 1, 4); Width0 = 5'd5; Req0 = 1'b1;
        wait_sig(SIG_G0, 10, "t1 grant0");
        Req0 = 1'b0;
        wait_sig(SIG_R0, 20, "t1 rdy0");
        checkv("t1 aout literal", Aout, mk5(1, 3, 4, 7, 9));
        check1("t1 err", Err, 1'b0);
        do_rack(1'b0);
        check1("t1 s_ack after rack", S_Ack, 1'b1);
        wait_sig(SIG_IDLE, 10, "t1 idle");
        check1("t1 one s_ack", ack_cnt == ack_base + 1, 1'b1);

        // Arbitration: three back-to-back rounds with both requesters asking
        Reset = 1'b1; tick(); Reset = 1'b0; tick();
        base = grant_log.size();
        Ain0 = mk5(3, 1, 2, 0, 0);  Width0 = 5'd3;
        Ain1 = mk5(4, 3, 2, 1, 0);  Width1 = 5'd4;
        Req0 = 1'b1; Req1 = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wait_sig(SIG_GANY, 10, "arb grant");
            own = Grant1;
            wait_sig(own ? SIG_R1 : SIG_R0, 20, "arb rdy");
            if (k == 2) begin
                Req0 = 1'b0; Req1 = 1'b0;
            end
            do_rack(own);
        end
        wait_sig(SIG_IDLE, 10, "arb idle");
        check1("arb grant count", grant_log.size() == base + 3, 1'b1);
        if (grant_log.size() >= base + 3)
            for (int k = 0; k < 3; k++)
                check1($sformatf("arb order round %0d", k), grant_log[base + k], exp_order[k]);

        // Oversized width: rejected, returned unchanged, engine untouched
        ack_base = ack_cnt; start_base = start_cnt;
        Ain1 = mk5(20, 10, 30, 0, 1); Width1 = 5'd31; Req1 = 1'b1;
        wait_sig(SIG_G1, 10, "rej grant1");
        check1("rej rdy1 with grant", Rdy1, 1'b1);
        check1("rej err", Err, 1'b1);
        checkv("rej aout literal", Aout, mk5(20, 10, 30, 0, 1));
        Req1 = 1'b0;
        do_rack(1'b1);
        check1("rej idle after rack", Busy, 1'b0);
        tick();
        check1("rej no s_start", start_cnt == start_base, 1'b1);
        check1("rej no s_ack", ack_cnt == ack_base, 1'b1);

        // Width 1: engine completes without reordering
        ack_base = ack_cnt;
        Ain0 = mk5(5, 2, 8, 0, 0); Width0 = 5'd1; Req0 = 1'b1;
        wait_sig(SIG_G0, 10, "w1 grant0");
        Req0 = 1'b0;
        wait_sig(SIG_R0, 20, "w1 rdy0");
        checkv("w1 aout literal", Aout, mk5(5, 2, 8, 0, 0));
        check1("w1 err", Err, 1'b0);
        do_rack(1'b0);
        wait_sig(SIG_IDLE, 10, "w1 idle");
        check1("w1 one s_ack", ack_cnt == ack_base + 1, 1'b1);

        // Reset during WAIT, then a fresh job
        eng_lat = 10;
        Ain0 = mk5(6, 1, 5, 2, 0); Width0 = 5'd4; Req0 = 1'b1;
        wait_sig(SIG_G0, 10, "rst grant0");
        Req0 = 1'b0;
        tick(); tick();
        Reset = 1'b1;
        tick();
        check_all_zero("rst mid-job");
        Reset = 1'b0;
        eng_lat = 3;
        Req0 = 1'b1;
        wait_sig(SIG_G0, 10, "rst regrant0");
        Req0 = 1'b0;
        wait_sig(SIG_R0, 20, "rst rdy0");
        checkv("rst aout literal", Aout, mk5(1, 2, 5, 6, 0));
        do_rack(1'b0);
        wait_sig(SIG_IDLE, 10, "rst idle");

        // Held delivery: Rack0 low for 20 cycles, Req1 pending, stray Rack1
        Ain0 = mk5(12, 0, 127, 3, 64); Width0 = 5'd5; Req0 = 1'b1;
        wait_sig(SIG_G0, 10, "hold grant0");
        Req0 = 1'b0;
        wait_sig(SIG_R0, 20, "hold rdy0");
        held = mk5(0, 3, 12, 64, 127);
        Ain1 = mk5(3, 2, 1, 0, 0); Width1 = 5'd3; Req1 = 1'b1;
        Rack1 = 1'b1;
        for (int i = 0; i < 20; i++) begin
            check1("hold rdy0", Rdy0, 1'b1);
            checkv("hold aout", Aout, held);
            check1("hold s_ack", S_Ack, 1'b0);
            check1("hold grant1", Grant1, 1'b0);
            tick();
        end
        Rack1 = 1'b0;
        do_rack(1'b0);
        check1("hold release grant1", Grant1, 1'b0);
        tick();
        check1("hold idle grant1", Grant1, 1'b0);
        check1("hold idle busy", Busy, 1'b0);
        tick();
        check1("hold late grant1", Grant1, 1'b1);
        Req1 = 1'b0;
        wait_sig(SIG_R1, 20, "hold rdy1");
        checkv("hold aout1 literal", Aout, mk5(1, 2, 3, 0, 0));
        do_rack(1'b1);
        wait_sig(SIG_IDLE, 10, "hold idle end");
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
